// File: rtl/lipsi_bcd_display_driver.sv
// Binary-to-BCD converter (shift-and-add-3) feeding a time-multiplexed
// four-digit, common-anode seven-segment display.
module lipsi_bcd_display_driver #(
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_LZ     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  input  logic        value_valid,
  output logic        ready,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [3:0]  anode,
  output logic [6:0]  seg
);

  localparam int RW = REFRESH_BITS + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [19:0]     shreg_q, shreg_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_val_q, pend_val_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            bcd_valid_q, bcd_valid_d;
  logic [RW-1:0]   refresh_q, refresh_d;

  logic [1:0]      sel;
  logic [3:0]      digit;
  logic            blank;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] r);
    logic [19:0] t;
    t = r;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d, input logic blk);
    logic [6:0] s;
    s = 7'b1111111;
    if (!blk) begin
      case (d)
        4'd0:    s = 7'b0000001;
        4'd1:    s = 7'b1001111;
        4'd2:    s = 7'b0010010;
        4'd3:    s = 7'b0000110;
        4'd4:    s = 7'b1001100;
        4'd5:    s = 7'b0100100;
        4'd6:    s = 7'b0100000;
        4'd7:    s = 7'b0001111;
        4'd8:    s = 7'b0000000;
        4'd9:    s = 7'b0000100;
        default: s = 7'b1111111;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          shreg_d = {12'b0, pend_val_q};
          cnt_d   = 3'd0;
          state_d = SHIFT;
          pend_d  = 1'b0;
          // A fresh request landing while the pending one is launched queues up behind it.
          if (value_valid) begin
            pend_d     = 1'b1;
            pend_val_d = value;
          end
        end else if (value_valid) begin
          shreg_d = {12'b0, value};
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = dabble_step(shreg_q);
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d       = shreg_q[19:8];
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && value_valid) begin
      pend_d     = 1'b1;
      pend_val_d = value;
    end
    refresh_d = refresh_q + RW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      pend_q      <= 1'b0;
      bcd_q       <= 12'd0;
      bcd_valid_q <= 1'b0;
      refresh_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      refresh_q   <= refresh_d;
    end
  end

  // Datapath registers: only meaningful while a conversion/pending flag says so.
  always_ff @(posedge clk) begin
    shreg_q    <= shreg_d;
    pend_val_q <= pend_val_d;
  end

  assign ready     = (state_q == IDLE);
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign sel       = refresh_q[RW-1 -: 2];

  // Display decodes only the registered result, never the shift register.
  always_comb begin
    anode = 4'b0111;
    digit = 4'd0;
    blank = 1'b0;
    case (sel)
      2'd0: begin
        anode = 4'b0111;
        digit = 4'd0;
        blank = (BLANK_LZ != 0);
      end
      2'd1: begin
        anode = 4'b1011;
        digit = bcd_q[11:8];
        blank = (BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0);
      end
      2'd2: begin
        anode = 4'b1101;
        digit = bcd_q[7:4];
        blank = (BLANK_LZ != 0) && (bcd_q[11:4] == 8'd0);
      end
      default: begin
        anode = 4'b1110;
        digit = bcd_q[3:0];
        blank = 1'b0;
      end
    endcase
    seg = seg_code(digit, blank);
  end

endmodule

// File: tb/tb_lipsi_bcd_display_driver.sv
// Bench for lipsi_bcd_display_driver: directed cases plus randomized traffic,
// checked every cycle against a decimal-arithmetic reference model.
module tb_lipsi_bcd_display_driver;

  localparam int RB = 2;

  logic        clk, reset;
  logic [7:0]  value;
  logic        value_valid;
  logic        ready, bcd_valid, ready0, bcd_valid0;
  logic [11:0] bcd, bcd0;
  logic [3:0]  anode, anode0;
  logic [6:0]  seg, seg0;

  lipsi_bcd_display_driver #(.REFRESH_BITS(RB), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .ready(ready), .bcd(bcd), .bcd_valid(bcd_valid), .anode(anode), .seg(seg));

  lipsi_bcd_display_driver #(.REFRESH_BITS(RB), .BLANK_LZ(0)) dut0 (
    .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
    .ready(ready0), .bcd(bcd0), .bcd_valid(bcd_valid0), .anode(anode0), .seg(seg0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 0;

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: decimal result, busy countdown, one-deep newest-wins pending slot.
  int   m_left = 0, m_cur = 0, m_val = 0, m_pval = 0, m_tick = 0;
  bit   m_pend = 0, m_vld = 0;

  function automatic logic [11:0] exp_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void exp_disp(input int v, input int idx, input bit blz,
                                   output logic [3:0] an, output logic [6:0] sg);
    int h, t, u, d;
    bit bl;
    h  = v / 100;
    t  = (v / 10) % 10;
    u  = v % 10;
    an = 4'b1111 ^ (4'b1000 >> idx);
    d  = (idx == 0) ? 0 : (idx == 1) ? h : (idx == 2) ? t : u;
    bl = blz && (idx == 0 || (idx == 1 && h == 0) || (idx == 2 && v < 10));
    sg = bl ? 7'b1111111 : seg_tbl[d];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_pend = 0; m_val = 0; m_vld = 0; m_tick = 0;
    end else begin
      m_tick++;
      m_vld = 0;
      if (m_left > 0) begin
        if (value_valid) begin m_pend = 1; m_pval = int'(value); end
        m_left--;
        if (m_left == 0) begin m_val = m_cur; m_vld = 1; end
      end else if (m_pend) begin
        m_cur = m_pval; m_left = 9; m_pend = 0;
        if (value_valid) begin m_pend = 1; m_pval = int'(value); end
      end else if (value_valid) begin
        m_cur = int'(value); m_left = 9;
      end
    end
  end

  logic [3:0] e_an;
  logic [6:0] e_sg, e_sg0;
  int         e_idx;

  always @(negedge clk) begin
    if (chk_on) begin
      e_idx = (m_tick >> RB) % 4;
      exp_disp(m_val, e_idx, 1'b1, e_an, e_sg);
      exp_disp(m_val, e_idx, 1'b0, e_an, e_sg0);
      chk("ready",      32'(ready),      32'(m_left == 0));
      chk("bcd",        32'(bcd),        32'(exp_bcd(m_val)));
      chk("bcd_valid",  32'(bcd_valid),  32'(m_vld));
      chk("anode",      32'(anode),      32'(e_an));
      chk("seg",        32'(seg),        32'(e_sg));
      chk("ready0",     32'(ready0),     32'(m_left == 0));
      chk("bcd0",       32'(bcd0),       32'(exp_bcd(m_val)));
      chk("bcd_valid0", 32'(bcd_valid0), 32'(m_vld));
      chk("anode0",     32'(anode0),     32'(e_an));
      chk("seg0",       32'(seg0),       32'(e_sg0));
    end
  end

  logic [11:0] res_q [$];
  always @(negedge clk) if (bcd_valid) res_q.push_back(bcd);

  task automatic send(input logic [7:0] v);
    @(posedge clk); #2;
    value = v; value_valid = 1'b1;
    @(posedge clk); #2;
    value_valid = 1'b0;
  endtask

  task automatic conv_lit(input logic [7:0] v, input logic [11:0] exp, input string nm);
    int n;
    n = 0;
    send(v);
    @(negedge clk);
    while (!ready && n < 30) begin n++; @(negedge clk); end
    chk({nm, "_busy_cycles"}, 32'(n), 32'd9);
    chk({nm, "_valid"}, 32'(bcd_valid), 32'd1);
    chk({nm, "_bcd"}, 32'(bcd), 32'(exp));
    chk({nm, "_model"}, 32'(exp_bcd(m_val)), 32'(exp));
    @(negedge clk);
    chk({nm, "_pulse_end"}, 32'(bcd_valid), 32'd0);
  endtask

  task automatic wait_anode(input logic [3:0] a, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (anode == a) ok = 1;
    end
    chk({nm, "_anode"}, 32'(anode), 32'(a));
  endtask

  task automatic seg_at(input logic [3:0] a, input logic [6:0] s1, input logic [6:0] s0,
                        input string nm);
    wait_anode(a, nm);
    chk({nm, "_seg"}, 32'(seg), 32'(s1));
    chk({nm, "_seg_nolz"}, 32'(seg0), 32'(s0));
  endtask

  logic [3:0] an_seq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] s5_seq [4] = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100};

  initial begin
    int nq;
    bit done;
    value = 8'd0; value_valid = 1'b0; reset = 1'b0;
    #1 reset = 1'b1;
    chk_on = 1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);
    chk("rst_anode", 32'(anode), 32'h7);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_seg_nolz", 32'(seg0), 32'h01);
    @(posedge clk); #2 reset = 1'b0;

    conv_lit(8'd233, 12'h233, "v233");
    conv_lit(8'd255, 12'h255, "v255");
    conv_lit(8'd0,   12'h000, "v0");
    seg_at(4'b1011, 7'b1111111, 7'b0000001, "v0_hund");
    seg_at(4'b1110, 7'b0000001, 7'b0000001, "v0_unit");

    conv_lit(8'd9, 12'h009, "v9");
    seg_at(4'b0111, 7'b1111111, 7'b0000001, "v9_thou");
    seg_at(4'b1011, 7'b1111111, 7'b0000001, "v9_hund");
    seg_at(4'b1101, 7'b1111111, 7'b0000001, "v9_tens");
    seg_at(4'b1110, 7'b0000100, 7'b0000100, "v9_unit");

    conv_lit(8'd5, 12'h005, "v5");
    wait_anode(4'b1110, "v5_sync_a");
    wait_anode(4'b0111, "v5_sync_b");
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(p == 0 && c == 0)) @(negedge clk);
        chk("v5_dwell_anode", 32'(anode), 32'(an_seq[p]));
        chk("v5_dwell_seg", 32'(seg), 32'(s5_seq[p]));
      end
    end

    nq = res_q.size();
    send(8'd7);
    repeat (2) @(posedge clk);
    send(8'd100);
    send(8'd42);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (res_q.size() >= nq + 2) done = 1;
    end
    chk("order_count", 32'(res_q.size()), 32'(nq + 2));
    if (res_q.size() >= nq + 2) begin
      chk("order_first", 32'(res_q[nq]), 32'h007);
      chk("order_second", 32'(res_q[nq + 1]), 32'h042);
    end
    repeat (20) @(negedge clk);
    chk("order_no_100", 32'(res_q.size()), 32'(nq + 2));

    nq = res_q.size();
    send(8'd233);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    repeat (15) @(negedge clk);
    chk("abort_no_valid", 32'(res_q.size()), 32'(nq));

    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      reset       = ($urandom_range(0, 149) == 0);
      value_valid = ($urandom_range(0, 2) == 0);
      value       = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #2;
    reset = 1'b0; value_valid = 1'b0;
    repeat (25) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
